// File: rtl/core_pkg.sv
// Shared core definitions: default widths, register-file select encoding and
// the default register-address type.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;

  typedef enum logic {
    RF_INT = 1'b0,
    RF_FLT = 1'b1
  } rf_sel_e;

  typedef logic [$clog2(NREG_DEFAULT)-1:0] reg_addr_t;

endpackage

// File: rtl/regstate_scoreboard.sv
// Per-register busy bits for long-latency destinations, with the rbusy and
// resv_ok lookups. Float busy bits exist only when REGSTATE_FPR_EN is defined.
module regstate_scoreboard
  import core_pkg::*;
#(
  parameter  int NREG = NREG_DEFAULT,
  parameter  int NRD  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NRD-1:0]    rfmode,
  input  logic [NRD*AW-1:0] rreg,
  input  logic [NRD-1:0]    rhit,
  output logic [NRD-1:0]    rbusy,
  input  logic            wenable,
  input  logic            wfmode,
  input  logic [AW-1:0]   wreg,
  input  logic            resv_enable,
  input  logic            resv_fmode,
  input  logic [AW-1:0]   resv_reg,
  output logic            resv_ok
);

  logic [NREG-1:0] busy_int;
  logic [NREG-1:0] busy_int_nxt;
  logic [NREG-1:0] busy_flt;
  logic            w_in_range;
  logic            r_in_range;
  logic            resv_file_ok;

  // Integer x0 and out-of-range addresses never report busy.
  function automatic logic busy_at(input logic [NREG-1:0] bi,
                                   input logic [NREG-1:0] bf,
                                   input logic            f,
                                   input logic [AW-1:0]   a);
    logic b;
    b = 1'b0;
    if (int'(a) < NREG) begin
      if (f == RF_INT) b = (a != '0) && bi[a];
      else             b = bf[a];
    end
    return b;
  endfunction

  assign w_in_range = (int'(wreg) < NREG);
  assign r_in_range = (int'(resv_reg) < NREG);

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    assign rbusy[i] = busy_at(busy_int, busy_flt, rfmode[i], rreg[i*AW +: AW]) && !rhit[i];
  end

`ifdef REGSTATE_FPR_EN
  assign resv_file_ok = 1'b1;
`else
  assign resv_file_ok = (resv_fmode == RF_INT);
`endif

  // Uses pre-edge busy, so a same-cycle write to the target does not help.
  assign resv_ok = resv_enable && resv_file_ok &&
                   !busy_at(busy_int, busy_flt, resv_fmode, resv_reg);

  // Clear on writeback first, then set on reservation: reserve wins a tie.
  always_comb begin
    busy_int_nxt = busy_int;
    if (wenable && w_in_range && wfmode == RF_INT) busy_int_nxt[wreg] = 1'b0;
    if (resv_ok && r_in_range && resv_fmode == RF_INT) busy_int_nxt[resv_reg] = 1'b1;
    busy_int_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_int <= '0;
    else       busy_int <= busy_int_nxt;
  end

`ifdef REGSTATE_FPR_EN
  logic [NREG-1:0] busy_flt_nxt;

  always_comb begin
    busy_flt_nxt = busy_flt;
    if (wenable && w_in_range && wfmode == RF_FLT) busy_flt_nxt[wreg] = 1'b0;
    if (resv_ok && r_in_range && resv_fmode == RF_FLT) busy_flt_nxt[resv_reg] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy_flt <= '0;
    else       busy_flt <= busy_flt_nxt;
  end
`else
  assign busy_flt = '0;
`endif

endmodule

// File: rtl/core_regstate.sv
// Architectural state: PC, integer and float register files, write-to-read
// bypass and busy scoreboard. Float file present only when REGSTATE_FPR_EN is defined.
module core_regstate
  import core_pkg::*;
#(
  parameter  int              XLEN     = XLEN_DEFAULT,
  parameter  int              NREG     = NREG_DEFAULT,
  parameter  int              NRD      = 2,
  parameter  logic [XLEN-1:0] PC_RESET = '0,
  localparam int              AW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pcenable,
  input  logic [XLEN-1:0]   next_pc,
  output logic [XLEN-1:0]   pc,
  input  logic [NRD-1:0]    rfmode,
  input  logic [NRD*AW-1:0] rreg,
  output logic [NRD*XLEN-1:0] reg_out,
  output logic [NRD-1:0]    rbusy,
  input  logic              wenable,
  input  logic              wfmode,
  input  logic [AW-1:0]     wreg,
  input  logic [XLEN-1:0]   wdata,
  input  logic              resv_enable,
  input  logic              resv_fmode,
  input  logic [AW-1:0]     resv_reg,
  output logic              resv_ok
);

  logic [NREG-1:0][XLEN-1:0] gpr;
  logic                      w_in_range;
  logic                      wr_int;
  logic                      wr_flt;
  logic [NRD-1:0]            rhit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         pc <= PC_RESET;
    else if (pcenable) pc <= next_pc;
  end

  assign w_in_range = (int'(wreg) < NREG);
  assign wr_int     = wenable && w_in_range && (wfmode == RF_INT) && (wreg != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       gpr <= '0;
    else if (wr_int) gpr[wreg] <= wdata;
  end

`ifdef REGSTATE_FPR_EN
  logic [NREG-1:0][XLEN-1:0] fpr;

  assign wr_flt = wenable && w_in_range && (wfmode == RF_FLT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       fpr <= '0;
    else if (wr_flt) fpr[wreg] <= wdata;
  end
`else
  assign wr_flt = 1'b0;
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic            in_range;
    logic [XLEN-1:0] stored;

    assign a        = rreg[i*AW +: AW];
    assign in_range = (int'(a) < NREG);
    // wr_int/wr_flt already exclude x0, out-of-range and absent-file writes.
    assign rhit[i]  = ((rfmode[i] == RF_INT) ? wr_int : wr_flt) && (wreg == a);

    always_comb begin
      stored = '0;
      if (in_range && rfmode[i] == RF_INT && a != '0) stored = gpr[a];
`ifdef REGSTATE_FPR_EN
      if (in_range && rfmode[i] == RF_FLT) stored = fpr[a];
`endif
    end

    assign reg_out[i*XLEN +: XLEN] = rhit[i] ? wdata : stored;
  end

  regstate_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD)
  ) u_scoreboard (
    .clk         (clk),
    .rstn        (rstn),
    .rfmode      (rfmode),
    .rreg        (rreg),
    .rhit        (rhit),
    .rbusy       (rbusy),
    .wenable     (wenable),
    .wfmode      (wfmode),
    .wreg        (wreg),
    .resv_enable (resv_enable),
    .resv_fmode  (resv_fmode),
    .resv_reg    (resv_reg),
    .resv_ok     (resv_ok)
  );

endmodule
